// File: rtl/ps2_keys_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ps2_keys_pkg
// Description : Shared PS/2 scancode constants, sequencer FSM state encoding
//               and small scancode classification helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package ps2_keys_pkg;

    localparam logic [7:0] KEY_BREAK  = 8'hF0;
    localparam logic [7:0] KEY_EXT    = 8'hE0;
    localparam logic [7:0] KEY_LSHIFT = 8'h12;
    localparam logic [7:0] KEY_RSHIFT = 8'h59;
    localparam logic [7:0] KEY_CAPS   = 8'h58;
    localparam logic [7:0] KEY_LANG   = 8'h0E;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_BRK     = 3'd1,
        ST_EXT     = 3'd2,
        ST_EXT_BRK = 3'd3,
        ST_ISSUE   = 3'd4,
        ST_WAIT    = 3'd5,
        ST_CAPTURE = 3'd6
    } key_state_t;

    // Keys that change translator state but never produce a character
    function automatic logic is_non_char(input logic [7:0] code);
        return (code == KEY_LSHIFT) || (code == KEY_RSHIFT) ||
               (code == KEY_CAPS)   || (code == KEY_LANG);
    endfunction

    // Toggle keys whose typematic repeats must not re-toggle the translator
    function automatic logic is_toggle(input logic [7:0] code);
        return (code == KEY_CAPS) || (code == KEY_LANG);
    endfunction

endpackage
`default_nettype wire

// File: rtl/key_char_fifo.sv
`default_nettype none
// ============================================================================
// Module      : key_char_fifo
// Description : Parameterised synchronous FIFO. Simultaneous push and pop are
//               both honoured (also when full); pop on empty is ignored and a
//               push into a full FIFO without a pop is dropped.
// Revision    : 1.0 - initial release
// ============================================================================
module key_char_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_CW = c_AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_CW-1:0]  r_count;
    logic             w_pop_ok;
    logic             w_push_ok;

    assign empty     = (r_count == '0);
    assign full      = (r_count == c_CW'(DEPTH));
    assign w_pop_ok  = pop && !empty;
    assign w_push_ok = push && (!full || w_pop_ok);
    assign count     = r_count;
    assign dout      = empty ? '0 : r_mem[r_rd_ptr];

    // Storage array: written on every accepted push
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + c_AW'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + c_AW'(1);
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + c_CW'(1);
                2'b01:   r_count <= r_count - c_CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/key_event_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : key_event_sequencer
// Description : Strips PS/2 break/extended prefixes, drives the scancode
//               translator with single-cycle make/break pulses, samples the
//               translated ascii after the lookup latency and buffers
//               printable characters in a small FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module key_event_sequencer
    import ps2_keys_pkg::*;
#(
    parameter int FIFO_DEPTH  = 8,
    parameter int LOOKUP_WAIT = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [7:0]                    rx_data,
    input  logic                          rx_valid,
    output logic [7:0]                    scancode,
    output logic                          push_down,
    output logic                          push_up,
    input  logic [7:0]                    ascii,
    output logic [7:0]                    out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          busy,
    output logic                          overflow
);

    localparam int                c_WAIT_W    = $clog2(LOOKUP_WAIT);
    localparam logic [c_WAIT_W-1:0] c_WAIT_INIT = c_WAIT_W'(LOOKUP_WAIT - 2);

    key_state_t          r_state;
    key_state_t          w_state_next;
    logic [7:0]          r_code;
    logic                r_is_break;
    logic                r_suppress;
    logic [7:0]          r_held_code;
    logic                r_held_valid;
    logic                r_skid_valid;
    logic [7:0]          r_skid_data;
    logic [c_WAIT_W-1:0] r_wait_cnt;
    logic                r_overflow;

    logic                w_accept;
    logic                w_byte_valid;
    logic [7:0]          w_byte;
    logic                w_latch;
    logic                w_latch_brk;
    logic                w_push_down;
    logic                w_push_up;
    logic                w_enq;
    logic                w_skid_drop;
    logic                w_fifo_drop;
    logic                w_fifo_full;
    logic                w_fifo_empty;

    // Prefix-tracking states can take a byte; the skid always goes first
    assign w_accept     = (r_state == ST_IDLE) || (r_state == ST_BRK) ||
                          (r_state == ST_EXT)  || (r_state == ST_EXT_BRK);
    assign w_byte_valid = w_accept && (r_skid_valid || rx_valid);
    assign w_byte       = r_skid_valid ? r_skid_data : rx_data;
    assign w_skid_drop  = !w_accept && rx_valid && r_skid_valid;
    assign w_fifo_drop  = w_enq && w_fifo_full && !out_ready;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode plus pulse and enqueue strobes
    always_comb begin
        w_state_next = r_state;
        w_latch      = 1'b0;
        w_latch_brk  = 1'b0;
        w_push_down  = 1'b0;
        w_push_up    = 1'b0;
        w_enq        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_byte_valid) begin
                    if (w_byte == KEY_BREAK) begin
                        w_state_next = ST_BRK;
                    end else if (w_byte == KEY_EXT) begin
                        w_state_next = ST_EXT;
                    end else begin
                        w_latch      = 1'b1;
                        w_state_next = ST_ISSUE;
                    end
                end
            end
            ST_BRK: begin
                if (w_byte_valid) begin
                    w_latch      = 1'b1;
                    w_latch_brk  = 1'b1;
                    w_state_next = ST_ISSUE;
                end
            end
            ST_EXT: begin
                if (w_byte_valid) begin
                    w_state_next = (w_byte == KEY_BREAK) ? ST_EXT_BRK : ST_IDLE;
                end
            end
            ST_EXT_BRK: begin
                if (w_byte_valid) begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                w_push_down  = !r_is_break && !r_suppress;
                w_push_up    = r_is_break;
                w_state_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (r_wait_cnt == '0) begin
                    w_state_next = r_is_break ? ST_IDLE : ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                w_enq        = !r_is_break && !is_non_char(r_code) && (ascii != 8'h00);
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Latched key event and typematic hold tracking
    always_ff @(posedge clk) begin
        if (reset) begin
            r_code       <= 8'h00;
            r_is_break   <= 1'b0;
            r_suppress   <= 1'b0;
            r_held_code  <= 8'h00;
            r_held_valid <= 1'b0;
        end else if (w_latch) begin
            r_code     <= w_byte;
            r_is_break <= w_latch_brk;
            r_suppress <= !w_latch_brk && r_held_valid &&
                          (w_byte == r_held_code) && is_toggle(w_byte);
            if (!w_latch_brk) begin
                r_held_code  <= w_byte;
                r_held_valid <= 1'b1;
            end else if (w_byte == r_held_code) begin
                r_held_valid <= 1'b0;
            end
        end
    end

    // One-entry skid absorbing bytes that arrive while a key is in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            r_skid_valid <= 1'b0;
            r_skid_data  <= 8'h00;
        end else if (w_accept) begin
            if (r_skid_valid) begin
                r_skid_valid <= rx_valid;
                if (rx_valid) begin
                    r_skid_data <= rx_data;
                end
            end
        end else if (rx_valid && !r_skid_valid) begin
            r_skid_valid <= 1'b1;
            r_skid_data  <= rx_data;
        end
    end

    // Lookup latency counter, loaded during the pulse cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wait_cnt <= '0;
        end else if (r_state == ST_ISSUE) begin
            r_wait_cnt <= c_WAIT_INIT;
        end else if ((r_state == ST_WAIT) && (r_wait_cnt != '0)) begin
            r_wait_cnt <= r_wait_cnt - c_WAIT_W'(1);
        end
    end

    // Drop indication, one cycle after the dropping event
    always_ff @(posedge clk) begin
        if (reset) begin
            r_overflow <= 1'b0;
        end else begin
            r_overflow <= w_skid_drop || w_fifo_drop;
        end
    end

    key_char_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk   (clk),
        .rst   (reset),
        .push  (w_enq),
        .din   (ascii),
        .pop   (out_ready),
        .dout  (out_data),
        .full  (w_fifo_full),
        .empty (w_fifo_empty),
        .count (fifo_count)
    );

    assign scancode  = r_code;
    assign push_down = w_push_down;
    assign push_up   = w_push_up;
    assign out_valid = !w_fifo_empty;
    assign busy      = (r_state != ST_IDLE) || r_skid_valid;
    assign overflow  = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_key_event_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_key_event_sequencer
// Description : Self-checking bench for key_event_sequencer with a registered
//               translator ROM and a cycle-indexed event reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_key_event_sequencer;

    localparam int DEPTH = 8;
    localparam int LW    = 2;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [7:0]    rx_data = 8'h00;
    logic          rx_valid = 1'b0;
    logic [7:0]    scancode;
    logic          push_down;
    logic          push_up;
    logic [7:0]    ascii;
    logic [7:0]    out_data;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [CW-1:0] fifo_count;
    logic          busy;
    logic          overflow;

    always #5 clk = ~clk;

    key_event_sequencer #(
        .FIFO_DEPTH  (DEPTH),
        .LOOKUP_WAIT (LW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .scancode   (scancode),
        .push_down  (push_down),
        .push_up    (push_up),
        .ascii      (ascii),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .fifo_count (fifo_count),
        .busy       (busy),
        .overflow   (overflow)
    );

    // Translator stand-in: 0x1C is 'a'/'A'; codes with low bits 00 have no char
    function automatic logic [7:0] rom(input logic [7:0] code, input logic shift);
        if (code == 8'h1C) return shift ? 8'h41 : 8'h61;
        if (code[1:0] == 2'b00) return 8'h00;
        return {shift, code[6:0]};
    endfunction

    logic rom_l = 1'b0;
    logic rom_r = 1'b0;

    // Registered ROM with its own shift tracking driven by the pulses
    always @(posedge clk) begin
        if (reset) begin
            ascii <= 8'h00;
            rom_l <= 1'b0;
            rom_r <= 1'b0;
        end else begin
            ascii <= rom(scancode, rom_l | rom_r);
            if (push_down && scancode == 8'h12) rom_l <= 1'b1;
            if (push_down && scancode == 8'h59) rom_r <= 1'b1;
            if (push_up && scancode == 8'h12) rom_l <= 1'b0;
            if (push_up && scancode == 8'h59) rom_r <= 1'b0;
        end
    end

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    // Reference model: scheduled events keyed by absolute cycle number
    int         m_free   = 0;
    int         m_pref   = 0;   // 0 none, 1 after F0, 2 after E0, 3 after E0 F0
    bit         m_skid_v = 0;
    logic [7:0] m_skid_d = 8'h00;
    bit         m_held_v = 0;
    logic [7:0] m_held_c = 8'h00;
    bit         m_l = 0;
    bit         m_r = 0;
    logic [7:0] m_code = 8'h00;
    int         p_cyc = -1;
    bit         p_dn = 0;
    bit         p_up = 0;
    logic [7:0] p_code = 8'h00;
    int         cap_cyc = -1;
    logic [7:0] cap_code = 8'h00;
    logic [7:0] mq[$];
    bit         m_ovf = 0;
    int         obs_dn = 0;
    int         obs_up = 0;
    int         obs_ovf = 0;

    task automatic m_key(input logic [7:0] b, input bit brk);
        m_code = b;
        p_cyc  = cyc + 1;
        p_code = b;
        if (brk) begin
            if (m_held_v && b == m_held_c) m_held_v = 0;
            p_dn    = 0;
            p_up    = 1;
            cap_cyc = -1;
            m_free  = cyc + 1 + LW;
        end else begin
            p_dn     = !(m_held_v && b == m_held_c && (b == 8'h58 || b == 8'h0E));
            p_up     = 0;
            m_held_v = 1;
            m_held_c = b;
            cap_cyc  = cyc + 1 + LW;
            cap_code = b;
            m_free   = cyc + 2 + LW;
        end
    endtask

    task automatic m_accept(input logic [7:0] b);
        case (m_pref)
            0: begin
                if (b == 8'hF0) m_pref = 1;
                else if (b == 8'hE0) m_pref = 2;
                else m_key(b, 0);
            end
            1: begin
                m_pref = 0;
                m_key(b, 1);
            end
            2: m_pref = (b == 8'hF0) ? 3 : 0;
            default: m_pref = 0;
        endcase
    endtask

    task automatic m_step();
        bit         ovf;
        logic [7:0] a;
        logic [7:0] b;
        ovf = 0;
        if (reset) begin
            m_free = 0; m_pref = 0; m_skid_v = 0; m_held_v = 0;
            m_l = 0; m_r = 0; m_code = 8'h00; p_cyc = -1; cap_cyc = -1;
            mq.delete();
        end else begin
            if (mq.size() != 0 && out_ready) void'(mq.pop_front());
            if (cap_cyc == cyc) begin
                a = rom(cap_code, m_l | m_r);
                if (!(cap_code inside {8'h12, 8'h59, 8'h58, 8'h0E}) && a != 8'h00) begin
                    if (mq.size() < DEPTH) mq.push_back(a);
                    else ovf = 1;
                end
            end
            if (p_cyc == cyc) begin
                if (p_dn && p_code == 8'h12) m_l = 1;
                if (p_dn && p_code == 8'h59) m_r = 1;
                if (p_up && p_code == 8'h12) m_l = 0;
                if (p_up && p_code == 8'h59) m_r = 0;
            end
            if (cyc >= m_free) begin
                if (m_skid_v) begin
                    b = m_skid_d;
                    if (rx_valid) m_skid_d = rx_data;
                    else m_skid_v = 0;
                    m_accept(b);
                end else if (rx_valid) begin
                    m_accept(rx_data);
                end
            end else if (rx_valid) begin
                if (!m_skid_v) begin
                    m_skid_v = 1;
                    m_skid_d = rx_data;
                end else begin
                    ovf = 1;
                end
            end
        end
        m_ovf = ovf;
        cyc++;
    endtask

    // Compare every output mid-cycle, then advance the model with this cycle's inputs
    always @(negedge clk) begin
        check("push_down",  push_down,  (p_cyc == cyc) && p_dn);
        check("push_up",    push_up,    (p_cyc == cyc) && p_up);
        check("scancode",   scancode,   m_code);
        check("out_valid",  out_valid,  mq.size() != 0);
        check("out_data",   out_data,   (mq.size() != 0) ? mq[0] : 8'h00);
        check("fifo_count", fifo_count, mq.size());
        check("overflow",   overflow,   m_ovf);
        check("busy",       busy,       (cyc < m_free) || (m_pref != 0) || m_skid_v);
        if (push_down) obs_dn++;
        if (push_up)   obs_up++;
        if (overflow)  obs_ovf++;
        m_step();
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int k);
        repeat (k) tick();
    endtask

    task automatic send(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        tick();
        rx_valid = 1'b0;
    endtask

    function automatic logic [7:0] pick();
        case ($urandom_range(0, 11))
            0:  return 8'h1C;
            1:  return 8'h12;
            2:  return 8'h59;
            3:  return 8'h58;
            4:  return 8'h0E;
            5:  return 8'hF0;
            6:  return 8'hE0;
            7:  return 8'h75;
            8:  return 8'h23;
            9:  return 8'h31;
            10: return 8'h2B;
            default: return 8'($urandom_range(0, 255));
        endcase
    endfunction

    int d_dn;
    int d_up;
    int d_ovf;

    initial begin
        reset = 1'b1;
        idle(3);
        reset = 1'b0;
        idle(2);

        // Single make of 'a'
        send(8'h1C);
        idle(10);

        // Break only: one push_up, no push_down, nothing queued
        d_dn = obs_dn; d_up = obs_up;
        send(8'hF0); send(8'h1C);
        idle(10);
        check("brk_dn_count", obs_dn - d_dn, 0);
        check("brk_up_count", obs_up - d_up, 1);
        check("brk_fifo", fifo_count, 0);

        // Shifted 'A'
        d_dn = obs_dn; d_up = obs_up;
        send(8'h12); idle(6);
        send(8'h1C); idle(6);
        send(8'hF0); send(8'h12); idle(8);
        check("shift_dn_count", obs_dn - d_dn, 2);
        check("shift_up_count", obs_up - d_up, 1);

        // Held caps lock toggles once
        d_dn = obs_dn;
        repeat (3) begin send(8'h58); idle(6); end
        check("caps_dn_count", obs_dn - d_dn, 1);
        check("caps_fifo", fifo_count, 0);

        // Extended keys are swallowed
        d_dn = obs_dn; d_up = obs_up;
        send(8'hE0); send(8'h75); idle(2);
        send(8'hE0); send(8'hF0); send(8'h75); idle(4);
        check("ext_pulses", (obs_dn - d_dn) + (obs_up - d_up), 0);
        check("ext_busy", busy, 0);

        // Back-to-back bytes: one processed, one skidded, one dropped
        out_ready = 1'b0;
        d_ovf = obs_ovf;
        send(8'h1C); send(8'h1C); send(8'h1C);
        idle(12);
        check("skid_ovf", obs_ovf - d_ovf, 1);
        check("skid_fifo", fifo_count, 2);
        out_ready = 1'b1;
        idle(4);

        // Fill the FIFO past capacity, then drain in order
        out_ready = 1'b0;
        d_ovf = obs_ovf;
        repeat (9) begin send(8'h1C); idle(9); end
        check("full_fifo", fifo_count, DEPTH);
        check("full_ovf", obs_ovf - d_ovf, 1);
        out_ready = 1'b1;
        idle(12);

        // Reset in the middle of WAIT
        send(8'h1C);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst_busy", busy, 0);
        check("rst_count", fifo_count, 0);
        idle(4);

        // Randomised traffic including occasional resets
        repeat (3000) begin
            rx_valid  = ($urandom_range(0, 99) < 35);
            rx_data   = pick();
            out_ready = ($urandom_range(0, 99) < 60);
            reset     = ($urandom_range(0, 999) == 0);
            tick();
        end
        rx_valid  = 1'b0;
        reset     = 1'b0;
        out_ready = 1'b1;
        idle(30);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
